// File: rtl/round_pkg.sv
// Shared types and widths for the game-round sequencer.
package round_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    WON     = 2'd2,
    LOST    = 2'd3
  } state_e;

  localparam int ROUND_W           = 8;
  localparam int LIVES_W           = 2;
  localparam int DEFAULT_MAX_ROUND = 100;
  localparam int DEFAULT_LIVES     = 3;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector. The history register resets to 1 so a level
// already high when reset releases is not mistaken for a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: owns the round number and lives count and reports
// the win/lose end states. All outputs are registered.
module round_controller
  import round_pkg::*;
#(
  parameter int MAX_ROUND = DEFAULT_MAX_ROUND,
  parameter int LIVES     = DEFAULT_LIVES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_btn,
  input  logic                 round_pass,
  input  logic                 round_fail,
  output logic [ROUND_W-1:0]   round,
  output logic [LIVES_W-1:0]   lives,
  output logic                 playing,
  output logic                 game_won,
  output logic                 game_over,
  output logic                 new_round
);

  localparam logic [ROUND_W-1:0] MAX_ROUND_V = ROUND_W'(MAX_ROUND);
  localparam logic [LIVES_W-1:0] LIVES_V     = LIVES_W'(LIVES);

  logic start_ev, pass_ev, fail_ev;

  rise_detect u_start (.clk(clk), .reset(reset), .d(start_btn),  .rise(start_ev));
  rise_detect u_pass  (.clk(clk), .reset(reset), .d(round_pass), .rise(pass_ev));
  rise_detect u_fail  (.clk(clk), .reset(reset), .d(round_fail), .rise(fail_ev));

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               new_round_q, new_round_d;
  logic               playing_q, game_won_q, game_over_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      lives_q     <= '0;
      new_round_q <= 1'b0;
      playing_q   <= 1'b0;
      game_won_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      lives_q     <= lives_d;
      new_round_q <= new_round_d;
      playing_q   <= (state_d == PLAYING);
      game_won_q  <= (state_d == WON);
      game_over_q <= (state_d == LOST);
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    lives_d     = lives_q;
    new_round_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        round_d = '0;
        lives_d = '0;
        if (start_ev) begin
          state_d     = PLAYING;
          round_d     = ROUND_W'(1);
          lives_d     = LIVES_V;
          new_round_d = 1'b1;
        end
      end
      PLAYING: begin
        // A failure outranks a pass landing in the same cycle.
        if (fail_ev) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d     = lives_q - LIVES_W'(1);
            new_round_d = 1'b1;
          end else begin
            lives_d = '0;
            state_d = LOST;
          end
        end else if (pass_ev) begin
          if (round_q < MAX_ROUND_V) begin
            round_d     = round_q + ROUND_W'(1);
            new_round_d = 1'b1;
          end else begin
            state_d = WON;
          end
        end
      end
      WON, LOST: begin
        if (start_ev) begin
          state_d     = PLAYING;
          round_d     = ROUND_W'(1);
          lives_d     = LIVES_V;
          new_round_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign round     = round_q;
  assign lives     = lives_q;
  assign playing   = playing_q;
  assign game_won  = game_won_q;
  assign game_over = game_over_q;
  assign new_round = new_round_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with hand-computed expectations.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       round_pass = 1'b0;
  logic       round_fail = 1'b0;
  logic [7:0] round;
  logic [1:0] lives;
  logic       playing, game_won, game_over, new_round;

  int n_vec  = 0;
  int n_miss = 0;
  int nr_cnt = 0;

  round_controller #(.MAX_ROUND(100), .LIVES(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .round_pass(round_pass), .round_fail(round_fail),
    .round(round), .lives(lives), .playing(playing),
    .game_won(game_won), .game_over(game_over), .new_round(new_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (new_round === 1'b1) nr_cnt++;
  endtask

  // Raise the selected inputs {start,pass,fail} for one cycle, then drop them.
  // nr_hi returns new_round seen right after the rising cycle.
  task automatic pulse(input logic [2:0] m, output logic nr_hi);
    start_btn  = m[2];
    round_pass = m[1];
    round_fail = m[0];
    tick();
    nr_hi = new_round;
    start_btn  = 1'b0;
    round_pass = 1'b0;
    round_fail = 1'b0;
    tick();
  endtask

  task automatic passes(input int n);
    logic nr;
    for (int i = 0; i < n; i++) pulse(3'b010, nr);
  endtask

  initial begin
    logic nr;
    // Reset with start held high: release must not create a start event.
    start_btn = 1'b1;
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_round", round, 0);
    check("rst_lives", lives, 0);
    check("rst_playing", playing, 0);
    check("rst_won", game_won, 0);
    check("rst_over", game_over, 0);
    check("rst_new_round", new_round, 0);
    reset = 1'b0;
    tick(); tick();
    check("held_start_round", round, 0);
    check("held_start_playing", playing, 0);

    // Genuine start
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    check("start_round", round, 1);
    check("start_lives", lives, 3);
    check("start_playing", playing, 1);
    check("start_new_round", new_round, 1);
    start_btn = 1'b0;
    tick();
    check("start_nr_drop", new_round, 0);

    // Four pass pulses plus one pass held for 10 cycles: five events
    nr_cnt = 0;
    passes(4);
    round_pass = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    round_pass = 1'b0;
    tick();
    check("pass5_round", round, 6);
    check("pass5_nr_count", nr_cnt, 5);

    // Start while playing is ignored
    pulse(3'b100, nr);
    check("start_ign_nr", nr, 0);
    check("start_ign_round", round, 6);
    check("start_ign_lives", lives, 3);

    // Three failures exhaust the lives
    pulse(3'b001, nr);
    check("fail1_lives", lives, 2);
    check("fail1_nr", nr, 1);
    check("fail1_round", round, 6);
    pulse(3'b001, nr);
    check("fail2_lives", lives, 1);
    check("fail2_nr", nr, 1);
    pulse(3'b001, nr);
    check("fail3_lives", lives, 0);
    check("fail3_nr", nr, 0);
    check("fail3_round", round, 6);
    check("fail3_over", game_over, 1);
    check("fail3_playing", playing, 0);
    pulse(3'b010, nr);
    check("lost_pass_round", round, 6);
    check("lost_pass_nr", nr, 0);

    // Restart from LOST and climb to the final round
    pulse(3'b100, nr);
    check("restart_nr", nr, 1);
    check("restart_round", round, 1);
    check("restart_lives", lives, 3);
    check("restart_over", game_over, 0);
    passes(99);
    check("r100_round", round, 100);
    check("r100_playing", playing, 1);
    pulse(3'b010, nr);
    check("win_round", round, 100);
    check("win_won", game_won, 1);
    check("win_playing", playing, 0);
    check("win_nr", nr, 0);
    pulse(3'b010, nr);
    check("won_pass_round", round, 100);
    pulse(3'b100, nr);
    check("won_restart_round", round, 1);
    check("won_restart_lives", lives, 3);
    check("won_restart_playing", playing, 1);
    check("won_restart_won", game_won, 0);

    // Round 10, lives 2, then pass and fail together: fail wins
    passes(9);
    pulse(3'b001, nr);
    check("pre_sim_round", round, 10);
    check("pre_sim_lives", lives, 2);
    pulse(3'b011, nr);
    check("sim_lives", lives, 1);
    check("sim_round", round, 10);
    check("sim_nr", nr, 1);
    check("sim_playing", playing, 1);

    // Mid-game reset at round 42 coinciding with a pass event
    passes(32);
    check("r42_round", round, 42);
    reset = 1'b1;
    round_pass = 1'b1;
    tick();
    check("midrst_round", round, 0);
    check("midrst_lives", lives, 0);
    check("midrst_playing", playing, 0);
    check("midrst_nr", new_round, 0);
    reset = 1'b0;
    tick();
    round_pass = 1'b0;
    tick();
    check("postrst_round", round, 0);
    check("postrst_playing", playing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
